pay_station: RTL
================

PAY_STATION -- requirements
Module: pay_station

Interface
REQ-001 clk  in  1  single system clock; all state updates on rising edge.
REQ-002 reset  in  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-003 Ent_Sens  in  1  one-cycle pulse: car entered lot; starts parking timer.
REQ-004 Tick_1  in  1  one-cycle time-base strobe; one parking time unit.
REQ-005 Ticket_Req  in  1  one-cycle pulse: driver presents ticket at pay station.
REQ-006 Coin_In  in  1  one-cycle pulse: one coin inserted.
REQ-007 Coin_Val  in  2  coin value, qualified by Coin_In: 00=1, 01=2, 10=5, 11=invalid.
REQ-008 Gate_Ack  in  1  one-cycle pulse from gate controller: car has exited on payment.
REQ-009 paid_stat  out  1  level: fee settled; held until Gate_Ack.
REQ-010 Fee_Due  out  4  remaining balance in coin units.
REQ-011 Change_Out  out  4  change or refund amount; held until next Ticket_Req.
REQ-012 Change_Vld  out  1  one-cycle pulse when Change_Out is updated.
REQ-013 Busy  out  1  high in COLLECT and PAID states.

Function
REQ-014 The block SHALL implement FSM states IDLE, PARKED, COLLECT, PAID; all outputs registered.
REQ-015 IDLE: Ent_Sens SHALL move to PARKED with 8-bit timer cleared to 0; other inputs ignored.
REQ-016 PARKED: each Tick_1 SHALL increment the timer, saturating at 255 (no wrap).
REQ-017 PARKED: Ticket_Req SHALL move to COLLECT, latch fee = min(15, 1 + timer[7:4]), drive Fee_Due = fee, clear 5-bit credit and 4-bit timeout count, and clear Change_Out.
REQ-018 COLLECT: Coin_In with valid Coin_Val SHALL add the coin value to credit; Fee_Due SHALL show max(0, fee - credit) one cycle later.
REQ-019 COLLECT: Coin_In with Coin_Val=11 SHALL be ignored and SHALL NOT reset the timeout count.
REQ-020 COLLECT: when credit >= fee after a coin, the next cycle SHALL enter PAID with paid_stat=1, Fee_Due=0, Change_Out=credit-fee (0..4), and Change_Vld pulsed once.
REQ-021 COLLECT: each Tick_1 without a valid coin in the same cycle SHALL increment the timeout count; a valid coin SHALL clear it.
REQ-022 COLLECT: if Tick_1 and a valid coin coincide, the coin SHALL be credited and the timeout count cleared.
REQ-023 COLLECT: on the 16th timeout tick, the FSM SHALL return to PARKED with Change_Out=credit (refund), Change_Vld pulsed once, Fee_Due=0, and credit cleared.
REQ-024 COLLECT and PAID: the parking timer SHALL keep counting on Tick_1, saturating at 255.
REQ-025 PAID: paid_stat SHALL stay 1 until Gate_Ack; on Gate_Ack the FSM SHALL enter IDLE with paid_stat=0 and the timer cleared.
REQ-026 PAID: Coin_In SHALL be ignored, with no credit and no change.
REQ-027 Ent_Sens in any state except IDLE SHALL be ignored; Ticket_Req outside PARKED SHALL be ignored; Gate_Ack outside PAID SHALL be ignored.

Reset
REQ-028 reset SHALL take priority over every input and override any in-progress transaction.
REQ-029 On reset the FSM SHALL enter IDLE with timer, credit, and timeout count cleared; paid_stat=0, Fee_Due=0, Change_Out=0, Change_Vld=0, Busy=0.
REQ-030 Reset asserted in COLLECT SHALL discard credit without a refund pulse.

Verification
REQ-031 reset, Ent_Sens, 40 Tick_1, Ticket_Req -> Fee_Due=3, Busy=1; coins 2,1 -> paid_stat=1 the cycle after the second coin, Change_Out=0, Change_Vld pulsed once.
REQ-032 Ent_Sens, 0 ticks, Ticket_Req -> Fee_Due=1; coin 5 -> PAID, Change_Out=4; Gate_Ack -> paid_stat=0, Busy=0, IDLE.
REQ-033 Ent_Sens, 300 Tick_1 -> timer=255; Ticket_Req -> Fee_Due=15; three coins of 5 -> paid_stat=1, Change_Out=0.
REQ-034 Fee 3, one coin 1, then 16 Tick_1 without coins -> back to PARKED, Change_Out=1, Change_Vld pulsed once, Fee_Due=0; a second Ticket_Req relatches the fee.
REQ-035 In COLLECT, Coin_Val=11 pulses -> credit unchanged; Tick_1 and a valid coin in the same cycle -> coin credited, timeout count=0.
REQ-036 reset in COLLECT with credit=2 -> next cycle IDLE, all outputs 0, no Change_Vld; Ent_Sens in PAID -> no effect.

Source files
------------

// File: rtl/pay_station.sv
// Parking pay station: parking timer, fee latch, coin collection with timeout refund.
// All outputs are registered; the next-state logic computes every register's next value.
module pay_station (
    input  logic       clk,
    input  logic       reset,
    input  logic       Ent_Sens,
    input  logic       Tick_1,
    input  logic       Ticket_Req,
    input  logic       Coin_In,
    input  logic [1:0] Coin_Val,
    input  logic       Gate_Ack,
    output logic       paid_stat,
    output logic [3:0] Fee_Due,
    output logic [3:0] Change_Out,
    output logic       Change_Vld,
    output logic       Busy
);

    typedef enum logic [1:0] {IDLE, PARKED, COLLECT, PAID} state_t;

    state_t     state, state_n;
    logic [7:0] timer, timer_n;
    logic [3:0] fee, fee_n;
    logic [4:0] credit, credit_n;
    logic [3:0] tmo, tmo_n;
    logic       paid_n, vld_n, busy_n;
    logic [3:0] fee_due_n, change_n;

    logic       coin_ok;
    logic [4:0] coin_amt;
    logic [4:0] fee_raw;
    logic [3:0] fee_calc;
    logic [4:0] sum;
    logic [4:0] owed;
    logic [4:0] over;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            timer      <= '0;
            fee        <= '0;
            credit     <= '0;
            tmo        <= '0;
            paid_stat  <= 1'b0;
            Fee_Due    <= '0;
            Change_Out <= '0;
            Change_Vld <= 1'b0;
            Busy       <= 1'b0;
        end else begin
            state      <= state_n;
            timer      <= timer_n;
            fee        <= fee_n;
            credit     <= credit_n;
            tmo        <= tmo_n;
            paid_stat  <= paid_n;
            Fee_Due    <= fee_due_n;
            Change_Out <= change_n;
            Change_Vld <= vld_n;
            Busy       <= busy_n;
        end
    end

    always_comb begin
        coin_ok = Coin_In && (Coin_Val != 2'b11);
        case (Coin_Val)
            2'b00:   coin_amt = 5'd1;
            2'b01:   coin_amt = 5'd2;
            2'b10:   coin_amt = 5'd5;
            default: coin_amt = 5'd0;
        endcase
        fee_raw  = 5'd1 + {1'b0, timer[7:4]};
        fee_calc = fee_raw[4] ? 4'd15 : fee_raw[3:0];
        sum      = credit + coin_amt;
        owed     = {1'b0, fee} - sum;
        over     = sum - {1'b0, fee};
    end

    always_comb begin
        state_n   = state;
        timer_n   = timer;
        fee_n     = fee;
        credit_n  = credit;
        tmo_n     = tmo;
        paid_n    = paid_stat;
        fee_due_n = Fee_Due;
        change_n  = Change_Out;
        vld_n     = 1'b0;

        // Parking timer runs in every occupied state; transitions below may clear it.
        if (Tick_1 && state != IDLE && timer != 8'hFF)
            timer_n = timer + 8'd1;

        case (state)
            IDLE: begin
                if (Ent_Sens) begin
                    state_n = PARKED;
                    timer_n = '0;
                end
            end
            PARKED: begin
                if (Ticket_Req) begin
                    state_n   = COLLECT;
                    fee_n     = fee_calc;
                    fee_due_n = fee_calc;
                    credit_n  = '0;
                    tmo_n     = '0;
                    change_n  = '0;
                end
            end
            COLLECT: begin
                // A valid coin wins over a coincident tick and restarts the timeout.
                if (coin_ok) begin
                    tmo_n    = '0;
                    credit_n = sum;
                    if (sum >= {1'b0, fee}) begin
                        state_n   = PAID;
                        paid_n    = 1'b1;
                        fee_due_n = '0;
                        change_n  = over[3:0];
                        vld_n     = 1'b1;
                    end else begin
                        fee_due_n = owed[3:0];
                    end
                end else if (Tick_1) begin
                    if (tmo == 4'd15) begin
                        state_n   = PARKED;
                        change_n  = credit[3:0];
                        vld_n     = 1'b1;
                        fee_due_n = '0;
                        credit_n  = '0;
                        tmo_n     = '0;
                    end else begin
                        tmo_n = tmo + 4'd1;
                    end
                end
            end
            PAID: begin
                if (Gate_Ack) begin
                    state_n = IDLE;
                    paid_n  = 1'b0;
                    timer_n = '0;
                end
            end
            default: state_n = IDLE;
        endcase

        busy_n = (state_n == COLLECT) || (state_n == PAID);
    end

endmodule
